serial_word_assembler: RTL and testbench
========================================

# serial_word_assembler

Upstream feeder for the 16-bit word-consuming stage. It collects a serial bit stream MSB-first into WIDTH-bit words and presents each completed word on a held parallel output with a valid/ready handshake. The downstream stage's 16-bit data input connects to `o_data`. Bit-level flow control stalls the serial source only when a completed word cannot be stored. A start-of-frame marker resynchronises word boundaries and flags truncated words.

## Interface
- WIDTH, 16, word width in bits; must be ≥ 2
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_bit  input  1  serial data bit
- i_bit_valid  input  1  i_bit is valid this cycle
- i_sof  input  1  qualifies the current bit as the first bit of a word; meaningful only when the bit is accepted
- o_bit_ready  output  1  block accepts a bit this cycle
- o_data  output  WIDTH  assembled word, MSB = first bit received
- o_valid  output  1  o_data holds an unconsumed word
- i_ready  input  1  downstream consumes o_data when o_valid is high
- o_frame_err  output  1  one-cycle pulse when a partial word is discarded by i_sof

## Operation
- State: shift register `sr` (WIDTH-1 bits used), bit counter `cnt` (0..WIDTH-1), and an output holding register (`o_data`, `o_valid`).
- Bit accept: `acc = i_bit_valid & o_bit_ready`.
- `o_bit_ready = ~(cnt == WIDTH-1 & ~i_sof & o_valid & ~i_ready)`.
  - This is combinational on i_ready and o_valid.
  - Stall only when the next bit would complete a word while the holder is full and not draining.
- acc with i_sof = 0 and cnt < WIDTH-1: shift `sr <= {sr, i_bit}`, then `cnt++`.
- acc with i_sof = 0 and cnt == WIDTH-1: word complete.
  - `o_data <= {sr[WIDTH-2:0], i_bit}`, `o_valid <= 1`, `cnt <= 0`.
- acc with i_sof = 1: the bit starts a new word, `sr <= i_bit`, `cnt <= 1`.
  - If cnt ≠ 0 beforehand, the partial word is dropped and o_frame_err pulses next cycle.
  - i_sof at cnt == 0 is legal and silent.
- i_sof without acc: ignored.
- Handshake: when `o_valid & i_ready`, the word is consumed.
  - If a word completes in the same cycle, o_data takes the new word and o_valid stays 1.
  - Otherwise o_valid falls to 0.
- o_data holds its value while o_valid = 0; it is only ever written on word completion.
- WIDTH = 1 is unsupported.

## Timing
- Reset values: o_data = 0, o_valid = 0, o_frame_err = 0, cnt = 0, sr = 0. o_bit_ready = 1 out of reset.
- Reset assertion clears state immediately, with no clock needed. A word in progress is discarded without o_frame_err.
- Reset release must be synchronous to i_clk; the integrating level provides the synchroniser.
- Latency: last bit accepted at edge N → o_valid = 1 and o_data valid after edge N.
- Throughput: 1 bit/cycle. Back-to-back words every WIDTH cycles with no bubble when i_ready = 1.
- o_frame_err is high for exactly the cycle after the offending accept edge.
- Inputs are sampled only at rising edges. There is no combinational path from i_bit to o_data.

## Structure
- Shared package `word_asm_pkg`:
  - `WORD_W` default = 16
  - `CNT_W = $clog2(WIDTH)`
  - reset constant for o_data
- One natural sub-module, `word_hold_reg`: the WIDTH-bit valid/ready holding register (load, consume, simultaneous load+consume).
- The shifter and counter stay in the top module.

## Test plan
- Reset: hold i_rst_n = 0 with i_bit_valid toggling → o_valid = 0, o_data = 16'h0000, o_bit_ready = 1.
  - Deassert, send 1010…10 (16 bits, i_sof on first) with i_ready = 1 → o_data = 16'hAAAA, o_valid high one cycle after the 16th accept.
- Back-to-back with i_ready = 1: send 16'hAAAA then 16'h5555 continuously.
  - o_valid pulses 16 cycles apart; o_data = 16'hAAAA then 16'h5555.
  - o_bit_ready never drops.
- Backpressure: i_ready = 0 after 16'h1234 completes, then stream 16'hABCD.
  - 15 bits accepted; o_bit_ready = 0 on the 16th while o_data stays 16'h1234.
  - Raise i_ready → 16th bit accepted in that cycle; o_data = 16'hABCD, o_valid stays 1.
- Frame error: send 5 bits, then i_sof with 16'hF00F.
  - o_frame_err one-cycle pulse after the i_sof accept.
  - o_data = 16'hF00F; the partial word never appears.
- Async reset mid-word: assert i_rst_n low between clock edges after 9 bits.
  - Outputs reset immediately, with no o_frame_err.
  - After release, a fresh 16'h8001 assembles correctly.
- Simultaneous drain/complete: o_valid = 1 holding 16'h00FF, i_ready = 1 on the cycle the 16th bit of 16'hFF00 is accepted → next cycle o_data = 16'hFF00, o_valid = 1.

Source files
------------

// File: rtl/word_asm_pkg.sv
// Shared definitions for the serial word assembler.
//   WORD_W      : default word width (the consuming stage takes 16-bit words)
//   CNT_W       : bit-counter width for the default word width
//   DATA_RST    : value o_data takes in reset
//   cnt_width() : counter width for an arbitrary word width
package word_asm_pkg;

    localparam int WORD_W = 16;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    localparam int CNT_W = cnt_width(WORD_W);

    localparam logic [WORD_W-1:0] DATA_RST = '0;

endpackage

// File: rtl/word_hold_reg.sv
// Valid/ready holding register for assembled words.
// A load always wins: loading while the current word is being consumed
// replaces it and keeps valid high. data is written only on load.
//   clk, rst_n : clock, async active-low reset
//   load       : capture load_data this cycle
//   load_data  : word to capture
//   ready      : downstream consumes data when valid is high
//   data       : held word
//   valid      : data holds an unconsumed word
module word_hold_reg
    import word_asm_pkg::*;
#(
    parameter int               WIDTH   = WORD_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= RST_VAL;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Collects an MSB-first serial bit stream into WIDTH-bit words and presents
// each completed word through a valid/ready holding register.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_bit          : serial data bit
//   i_bit_valid    : i_bit valid this cycle
//   i_sof          : accepted bit is the first bit of a word
//   o_bit_ready    : a bit is accepted this cycle
//   o_data         : assembled word, MSB = first bit received
//   o_valid        : o_data holds an unconsumed word
//   i_ready        : downstream consumes o_data when o_valid is high
//   o_frame_err    : one-cycle pulse when a partial word is dropped by i_sof
module serial_word_assembler
    import word_asm_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bit,
    input  logic             i_bit_valid,
    input  logic             i_sof,
    output logic             o_bit_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_frame_err
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam int             SR_W = WIDTH - 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [SR_W-1:0] sr;
    logic [CW-1:0]   cnt;
    logic            acc;
    logic            at_last;
    logic            word_done;

    assign at_last = (cnt == LAST);

    // Stall only when this bit would complete a word that has nowhere to go.
    // An i_sof bit never completes a word, so it is never stalled.
    assign o_bit_ready = ~(at_last & ~i_sof & o_valid & ~i_ready);
    assign acc         = i_bit_valid & o_bit_ready;
    assign word_done   = acc & ~i_sof & at_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr          <= '0;
            cnt         <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            if (acc) begin
                if (i_sof) begin
                    sr          <= SR_W'(i_bit);
                    cnt         <= CW'(1);
                    o_frame_err <= (cnt != '0);
                end else if (at_last) begin
                    cnt <= '0;
                end else begin
                    sr  <= SR_W'({sr, i_bit});
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    word_hold_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (WIDTH'(DATA_RST))
    ) u_hold (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (word_done),
        .load_data ({sr, i_bit}),
        .ready     (i_ready),
        .data      (o_data),
        .valid     (o_valid)
    );

endmodule

// File: tb/tb_serial_word_assembler.sv
module tb_serial_word_assembler;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_bit = 1'b0;
    logic         i_bit_valid = 1'b0;
    logic         i_sof = 1'b0;
    logic         o_bit_ready;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic         o_frame_err;

    int tests = 0;
    int fails = 0;

    // reference model: bits of the word in progress, held word, error pulse
    bit           part[$];
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_err = 1'b0;
    logic         exp_rdy;
    logic         obs_rdy;
    logic         last_acc;

    serial_word_assembler #(.WIDTH(W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .i_sof       (i_sof),
        .o_bit_ready (o_bit_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        part.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock: drive at the falling edge, sample ready before the rising
    // edge, advance the model at the rising edge, return 1 time unit after.
    task automatic drive_cycle(input logic b, input logic v, input logic s, input logic r);
        logic [W-1:0] word;
        logic         done;
        logic         err;
        @(negedge i_clk);
        i_bit = b; i_bit_valid = v; i_sof = s; i_ready = r;
        #1;
        obs_rdy = o_bit_ready;
        // a word with nowhere to go blocks only the bit that would finish it
        exp_rdy = !(part.size() == W-1 && !s && m_valid && !r);
        last_acc = v && exp_rdy;
        @(posedge i_clk);
        done = 1'b0;
        err  = 1'b0;
        word = '0;
        if (last_acc) begin
            if (s) begin
                err = (part.size() != 0);
                part.delete();
            end
            part.push_back(b);
            if (part.size() == W) begin
                foreach (part[k]) word = (word << 1) | W'(part[k]);
                part.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            m_data  = word;
            m_valid = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        m_err = err;
        #1;
    endtask

    // send a word MSB first, retrying stalled bits (bounded)
    task automatic send_word(input logic [W-1:0] w, input logic sof, input logic r);
        for (int i = W-1; i >= 0; i--) begin
            int tries = 0;
            do begin
                drive_cycle(w[i], 1'b1, sof && (i == W-1), r);
                tries++;
            end while (!last_acc && tries < 8);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            i_bit_valid = ~i_bit_valid;
            i_bit = 1'b1;
        end
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        tests++; if (o_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", o_data); end
        tests++; if (o_bit_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", o_bit_ready); end
        tests++; if (o_frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", o_frame_err); end
        @(negedge i_clk);
        i_bit_valid = 1'b0;
        i_rst_n = 1'b1;
        send_word(16'hAAAA, 1'b1, 1'b1);
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %b expected 1", o_valid); end
        tests++; if (o_data !== 16'hAAAA) begin fails++; $display("FAIL first_data: got %h expected aaaa", o_data); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2];
        int n = 0;
        int rdy_drops = 0;
        words[0] = 16'hAAAA;
        words[1] = 16'h5555;
        for (int w = 0; w < 2; w++) begin
            for (int i = W-1; i >= 0; i--) begin
                drive_cycle(words[w][i], 1'b1, (w == 0) && (i == W-1), 1'b1);
                n++;
                if (obs_rdy !== 1'b1) rdy_drops++;
                if (n == 16 || n == 32) begin
                    tests++; if (o_valid !== 1'b1 || o_data !== words[w]) begin
                        fails++; $display("FAIL b2b_word%0d: got v=%b %h expected v=1 %h", w, o_valid, o_data, words[w]);
                    end
                end
                if (n == 17) begin
                    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b expected 0", o_valid); end
                end
            end
        end
        tests++; if (rdy_drops != 0) begin fails++; $display("FAIL b2b_ready_drops: got %0d expected 0", rdy_drops); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w2 = 16'hABCD;
        send_word(16'h1234, 1'b1, 1'b0);
        for (int i = W-1; i >= 1; i--) drive_cycle(w2[i], 1'b1, i == W-1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(w2[0], 1'b1, 1'b0, 1'b0);
            tests++; if (obs_rdy !== 1'b0) begin fails++; $display("FAIL bp_stall: got %b expected 0", obs_rdy); end
            tests++; if (o_data !== 16'h1234 || o_valid !== 1'b1) begin
                fails++; $display("FAIL bp_hold: got v=%b %h expected v=1 1234", o_valid, o_data);
            end
        end
        drive_cycle(w2[0], 1'b1, 1'b0, 1'b1);
        tests++; if (obs_rdy !== 1'b1) begin fails++; $display("FAIL bp_release: got %b expected 1", obs_rdy); end
        tests++; if (o_data !== 16'hABCD || o_valid !== 1'b1) begin
            fails++; $display("FAIL bp_word: got v=%b %h expected v=1 abcd", o_valid, o_data);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_frame_err();
        logic [W-1:0] w = 16'hF00F;
        for (int i = 0; i < 5; i++) drive_cycle(1'($urandom_range(0, 1)), 1'b1, i == 0, 1'b1);
        for (int i = W-1; i >= 0; i--) begin
            drive_cycle(w[i], 1'b1, i == W-1, 1'b1);
            if (i == W-1) begin
                tests++; if (o_frame_err !== 1'b1) begin fails++; $display("FAIL ferr_pulse: got %b expected 1", o_frame_err); end
            end
            if (i == W-2) begin
                tests++; if (o_frame_err !== 1'b0) begin fails++; $display("FAIL ferr_width: got %b expected 0", o_frame_err); end
            end
            if (i > 0 && o_valid !== 1'b0) begin
                tests++; fails++; $display("FAIL ferr_partial: got v=1 %h expected v=0", o_data);
            end
        end
        tests++; if (o_data !== 16'hF00F || o_valid !== 1'b1) begin
            fails++; $display("FAIL ferr_word: got v=%b %h expected v=1 f00f", o_valid, o_data);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        tests++; if (o_frame_err !== 1'b0) begin fails++; $display("FAIL sof_no_acc: got %b expected 0", o_frame_err); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w = 16'h8001;
        send_word(16'h3C5A, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 1'b1, i == 0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (o_valid !== 1'b0 || o_data !== 16'h0000) begin
            fails++; $display("FAIL arst_out: got v=%b %h expected v=0 0000", o_valid, o_data);
        end
        tests++; if (o_frame_err !== 1'b0 || o_bit_ready !== 1'b1) begin
            fails++; $display("FAIL arst_flags: got err=%b rdy=%b expected err=0 rdy=1", o_frame_err, o_bit_ready);
        end
        @(negedge i_clk);
        i_bit_valid = 1'b0;
        i_rst_n = 1'b1;
        for (int i = W-1; i >= 0; i--) begin
            drive_cycle(w[i], 1'b1, i == W-1, 1'b1);
            if (i == W-1) begin
                tests++; if (o_frame_err !== 1'b0) begin fails++; $display("FAIL arst_no_err: got %b expected 0", o_frame_err); end
            end
        end
        tests++; if (o_data !== 16'h8001 || o_valid !== 1'b1) begin
            fails++; $display("FAIL arst_word: got v=%b %h expected v=1 8001", o_valid, o_data);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_simul_drain();
        logic [W-1:0] w = 16'hFF00;
        send_word(16'h00FF, 1'b1, 1'b0);
        for (int i = W-1; i >= 1; i--) drive_cycle(w[i], 1'b1, i == W-1, 1'b0);
        tests++; if (o_data !== 16'h00FF || o_valid !== 1'b1) begin
            fails++; $display("FAIL sim_before: got v=%b %h expected v=1 00ff", o_valid, o_data);
        end
        drive_cycle(w[0], 1'b1, 1'b0, 1'b1);
        tests++; if (o_data !== 16'hFF00 || o_valid !== 1'b1) begin
            fails++; $display("FAIL sim_after: got v=%b %h expected v=1 ff00", o_valid, o_data);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 2000; c++) begin
            drive_cycle(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 9) < 8),
                        ($urandom_range(0, 39) == 0),
                        ($urandom_range(0, 3) != 0));
            tests++;
            if (obs_rdy !== exp_rdy || o_valid !== m_valid || o_data !== m_data || o_frame_err !== m_err) begin
                fails++;
                if (bad < 10) $display("FAIL rand_c%0d: got rdy=%b v=%b d=%h err=%b expected rdy=%b v=%b d=%h err=%b",
                                       c, obs_rdy, o_valid, o_data, o_frame_err, exp_rdy, m_valid, m_data, m_err);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_frame_err();
        test_async_reset();
        test_simul_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
